// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage.
// Holds the opcode encodings, the control bundle carried into ID/EX,
// the bubble value and the opcode-to-control decoder.
package id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BGEZ  = 6'b000001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Control bundle: m[2] branch, m[1] mem read, m[0] mem write
    typedef struct packed {
        logic [5:0] ex;
        logic [2:0] m;
        logic [1:0] wb;
        logic       jump;
    } ctrl_t;

    localparam ctrl_t ID_CTRL_BUBBLE = '{ex: 6'b0, m: 3'b0, wb: 2'b0, jump: 1'b0};

    // Opcode to control; unknown opcodes decode to a bubble
    function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
        ctrl_t c;
        c = ID_CTRL_BUBBLE;
        case (opcode)
            OP_RTYPE: c = '{ex: 6'b100100, m: 3'b000, wb: 2'b10, jump: 1'b0};
            OP_ADDI,
            OP_ADDIU: c = '{ex: 6'b000001, m: 3'b000, wb: 2'b10, jump: 1'b0};
            OP_ANDI:  c = '{ex: 6'b000111, m: 3'b000, wb: 2'b10, jump: 1'b0};
            OP_BEQ:   c = '{ex: 6'b000010, m: 3'b100, wb: 2'b00, jump: 1'b1};
            OP_BGEZ:  c = '{ex: 6'b000100, m: 3'b100, wb: 2'b00, jump: 1'b1};
            OP_LW:    c = '{ex: 6'b000001, m: 3'b010, wb: 2'b11, jump: 1'b0};
            OP_SW:    c = '{ex: 6'b000001, m: 3'b001, wb: 2'b00, jump: 1'b0};
            default:  c = ID_CTRL_BUBBLE;
        endcase
        return c;
    endfunction

    // True for every opcode the decoder understands
    function automatic logic opcode_known(input logic [5:0] opcode);
        logic k;
        case (opcode)
            OP_RTYPE, OP_ADDI, OP_ADDIU, OP_ANDI,
            OP_BEQ, OP_BGEZ, OP_LW, OP_SW: k = 1'b1;
            default:                        k = 1'b0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/id_regfile.sv
// Architectural register file with one clocked write port and two
// combinational read ports that bypass a same-cycle write.
// Ports: clk, rst (async, active high), we/waddr/wdata write port,
//        raddr_1/raddr_2 read addresses, rdata_1/rdata_2 read data.
module id_regfile
    import id_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned REG_DEPTH = 32,
    parameter int unsigned ZERO_REG  = 1,
    localparam int unsigned ADDR_W   = $clog2(REG_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_1,
    input  logic [ADDR_W-1:0] raddr_2,
    output logic [DATA_W-1:0] rdata_1,
    output logic [DATA_W-1:0] rdata_2
);

    logic [DATA_W-1:0] regs [REG_DEPTH];
    logic              wr_ok;

    // Writes to register 0 vanish when it is hard-wired to zero
    assign wr_ok = we && !(ZERO_REG != 0 && waddr == '0);

    // Write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(REG_DEPTH); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[waddr] <= wdata;
        end
    end

    // Read ports: write-through bypass, then zero-register override
    always_comb begin
        rdata_1 = regs[raddr_1];
        if (wr_ok && waddr == raddr_1) rdata_1 = wdata;
        if (ZERO_REG != 0 && raddr_1 == '0) rdata_1 = '0;
    end

    always_comb begin
        rdata_2 = regs[raddr_2];
        if (wr_ok && waddr == raddr_2) rdata_2 = wdata;
        if (ZERO_REG != 0 && raddr_2 == '0) rdata_2 = '0;
    end

endmodule

// File: rtl/id_stage_param.sv
// Decode stage: register read, control decode, immediate extension,
// branch resolution, load-use stall and the ID/EX pipeline register.
// Ports: clk/rst; inst_in, if_valid, pc, flush_id from IF/ID;
//        wb_we/wb_addr/wb_data write-back; hold_pc/hold_if stall;
//        br/pc_branch/exception (combinational);
//        ex_valid, ex, m, wb, rs, rt, rd, imm, data_1, data_2 (ID/EX).
module id_stage_param
    import id_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned REG_DEPTH = 32,
    parameter int unsigned LOAD_LAT  = 1,
    parameter int unsigned ZERO_REG  = 1,
    localparam int unsigned ADDR_W   = $clog2(REG_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       inst_in,
    input  logic              if_valid,
    input  logic [DATA_W-1:0] pc,
    input  logic              flush_id,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              hold_pc,
    output logic              hold_if,
    output logic              br,
    output logic [DATA_W-1:0] pc_branch,
    output logic              exception,
    output logic              ex_valid,
    output logic [5:0]        ex,
    output logic [2:0]        m,
    output logic [1:0]        wb,
    output logic [ADDR_W-1:0] rs,
    output logic [ADDR_W-1:0] rt,
    output logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] data_1,
    output logic [DATA_W-1:0] data_2
);

    localparam int unsigned CNT_W = 2;

    logic [5:0]        opcode;
    logic [ADDR_W-1:0] rs_id, rt_id, rd_id;
    logic [DATA_W-1:0] op1, op2, imm_ext;
    ctrl_t             ctrl;
    logic              taken, hz, stall, bubble;
    logic [CNT_W-1:0]  stall_cnt;

    assign opcode = inst_in[31:26];
    assign rs_id  = ADDR_W'(inst_in[25:21]);
    assign rt_id  = ADDR_W'(inst_in[20:16]);
    assign rd_id  = ADDR_W'(inst_in[15:11]);
    assign ctrl   = decode_ctrl(opcode);

    id_regfile #(
        .DATA_W    (DATA_W),
        .REG_DEPTH (REG_DEPTH),
        .ZERO_REG  (ZERO_REG)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (wb_we),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_1 (rs_id),
        .raddr_2 (rt_id),
        .rdata_1 (op1),
        .rdata_2 (op2)
    );

    // ANDI is the only zero-extending immediate
    always_comb begin
        if (opcode == OP_ANDI) imm_ext = DATA_W'(inst_in[15:0]);
        else                   imm_ext = {{(DATA_W-16){inst_in[15]}}, inst_in[15:0]};
    end

    assign pc_branch = pc + DATA_W'(4) + (imm_ext << 2);

    // Branch condition on the bypassed operands
    always_comb begin
        taken = 1'b0;
        case (opcode)
            OP_BEQ:  taken = (op1 == op2);
            OP_BGEZ: taken = !op1[DATA_W-1];
            default: taken = 1'b0;
        endcase
    end

    // Load in EX whose target feeds the instruction in ID
    assign hz = ex_valid && m[1] && (rt == rs_id || rt == rt_id)
                && !(ZERO_REG != 0 && rt == '0);

    assign stall     = (hz || stall_cnt != '0) && !flush_id && if_valid;
    assign hold_pc   = stall;
    assign hold_if   = stall;
    assign exception = !opcode_known(opcode) && if_valid && !flush_id;
    assign br        = taken && ctrl.jump && if_valid && !flush_id && !stall;
    assign bubble    = stall || flush_id || !if_valid || exception;

    // Remaining stall cycles after the one that detected the hazard
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (!stall) begin
            stall_cnt <= '0;
        end else if (stall_cnt != '0) begin
            stall_cnt <= stall_cnt - CNT_W'(1);
        end else begin
            stall_cnt <= CNT_W'(LOAD_LAT - 1);
        end
    end

    // ID/EX register; operand fields are captured even for bubbles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex       <= '0;
            m        <= '0;
            wb       <= '0;
            rs       <= '0;
            rt       <= '0;
            rd       <= '0;
            imm      <= '0;
            data_1   <= '0;
            data_2   <= '0;
        end else begin
            ex_valid <= !bubble;
            ex       <= bubble ? '0 : ctrl.ex;
            m        <= bubble ? '0 : ctrl.m;
            wb       <= bubble ? '0 : ctrl.wb;
            rs       <= rs_id;
            rt       <= rt_id;
            rd       <= rd_id;
            imm      <= imm_ext;
            data_1   <= op1;
            data_2   <= op2;
        end
    end

endmodule

// File: tb/tb_id_stage_param.sv
// Self-checking bench for id_stage_param: two instances (load latency 1
// and 3) share stimulus; expectations are queued when inputs are driven
// and popped when the outputs are sampled.
module tb_id_stage_param;
    import id_pkg::*;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       inst_in;
    logic              if_valid;
    logic [DATA_W-1:0] pc;
    logic              flush_id;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    logic              hold_pc_a, hold_if_a, br_a, exception_a, ex_valid_a;
    logic [DATA_W-1:0] pc_branch_a, imm_a, data_1_a, data_2_a;
    logic [5:0]        ex_a;
    logic [2:0]        m_a;
    logic [1:0]        wb_a;
    logic [ADDR_W-1:0] rs_a, rt_a, rd_a;

    logic              hold_pc_b, hold_if_b, br_b, exception_b, ex_valid_b;
    logic [DATA_W-1:0] pc_branch_b, imm_b, data_1_b, data_2_b;
    logic [5:0]        ex_b;
    logic [2:0]        m_b;
    logic [1:0]        wb_b;
    logic [ADDR_W-1:0] rs_b, rt_b, rd_b;

    always #5 clk = ~clk;

    id_stage_param #(.DATA_W(32), .REG_DEPTH(32), .LOAD_LAT(1), .ZERO_REG(1)) u_dut_a (
        .clk(clk), .rst(rst), .inst_in(inst_in), .if_valid(if_valid), .pc(pc),
        .flush_id(flush_id), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .hold_pc(hold_pc_a), .hold_if(hold_if_a), .br(br_a), .pc_branch(pc_branch_a),
        .exception(exception_a), .ex_valid(ex_valid_a), .ex(ex_a), .m(m_a), .wb(wb_a),
        .rs(rs_a), .rt(rt_a), .rd(rd_a), .imm(imm_a), .data_1(data_1_a), .data_2(data_2_a)
    );

    id_stage_param #(.DATA_W(32), .REG_DEPTH(32), .LOAD_LAT(3), .ZERO_REG(1)) u_dut_b (
        .clk(clk), .rst(rst), .inst_in(inst_in), .if_valid(if_valid), .pc(pc),
        .flush_id(flush_id), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .hold_pc(hold_pc_b), .hold_if(hold_if_b), .br(br_b), .pc_branch(pc_branch_b),
        .exception(exception_b), .ex_valid(ex_valid_b), .ex(ex_b), .m(m_b), .wb(wb_b),
        .rs(rs_b), .rt(rt_b), .rd(rd_b), .imm(imm_b), .data_1(data_1_b), .data_2(data_2_b)
    );

    typedef enum int {
        S_HOLD_A, S_HOLDIF_A, S_HOLD_B, S_HOLDIF_B, S_BR, S_PCB, S_EXC,
        S_EXV_A, S_EXV_B, S_EX, S_M, S_WB, S_IMM, S_D1_A, S_D2_A, S_D1_B, S_RD_A
    } sel_e;

    typedef struct {
        string       tag;
        sel_e        sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] observe(input sel_e s);
        case (s)
            S_HOLD_A:   return 32'(hold_pc_a);
            S_HOLDIF_A: return 32'(hold_if_a);
            S_HOLD_B:   return 32'(hold_pc_b);
            S_HOLDIF_B: return 32'(hold_if_b);
            S_BR:       return 32'(br_a);
            S_PCB:      return pc_branch_a;
            S_EXC:      return 32'(exception_a);
            S_EXV_A:    return 32'(ex_valid_a);
            S_EXV_B:    return 32'(ex_valid_b);
            S_EX:       return 32'(ex_a);
            S_M:        return 32'(m_a);
            S_WB:       return 32'(wb_a);
            S_IMM:      return imm_a;
            S_D1_A:     return data_1_a;
            S_D2_A:     return data_2_a;
            S_D1_B:     return data_1_b;
            S_RD_A:     return 32'(rd_a);
            default:    return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic push(input string tag, input sel_e s, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = s;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check_sb();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    // Combinational outputs after the inputs settle
    task automatic settle();
        #1;
        check_sb();
    endtask

    // Registered outputs just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
        check_sb();
    endtask

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs_f,
                                           input logic [4:0] rt_f, input logic [15:0] im);
        return {op, rs_f, rt_f, im};
    endfunction

    function automatic logic [31:0] r_type(input logic [4:0] rs_f, input logic [4:0] rt_f,
                                           input logic [4:0] rd_f);
        return {OP_RTYPE, rs_f, rt_f, rd_f, 5'd0, 6'h20};
    endfunction

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_we   = 1'b1;
        wb_addr = a;
        wb_data = d;
    endtask

    initial begin
        rst = 1'b1; inst_in = '0; if_valid = 1'b0; pc = '0; flush_id = 1'b0;
        wb_we = 1'b0; wb_addr = '0; wb_data = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        push("rst_exv", S_EXV_A, 0); push("rst_ex", S_EX, 0); push("rst_m", S_M, 0);
        push("rst_d1", S_D1_A, 0); push("rst_imm", S_IMM, 0);
        push("rst_hold_a", S_HOLD_A, 0); push("rst_hold_b", S_HOLD_B, 0);
        settle();
        rst = 1'b0;

        // Same-cycle write is bypassed into the ADDI operand
        wb_write(5'd5, 32'h1234);
        inst_in = i_type(OP_ADDI, 5'd5, 5'd6, 16'h0001); if_valid = 1'b1; pc = 32'h40;
        push("bypass_d1", S_D1_A, 32'h1234); push("addi_ex", S_EX, 32'b000001);
        push("addi_wb", S_WB, 32'b10); push("addi_exv", S_EXV_A, 1);
        tick();

        // Idle slot inserts a bubble
        wb_write(5'd1, 32'd7); if_valid = 1'b0;
        push("invalid_bubble", S_EXV_A, 0);
        tick();

        // BEQ taken, backwards target
        wb_write(5'd2, 32'd7);
        inst_in = i_type(OP_BEQ, 5'd1, 5'd2, 16'hFFFE); pc = 32'h100; if_valid = 1'b1;
        push("beq_br", S_BR, 1); push("beq_target", S_PCB, 32'h0FC); push("beq_exc", S_EXC, 0);
        settle();
        push("beq_m", S_M, 32'b100); push("beq_ex", S_EX, 32'b000010);
        push("beq_d2", S_D2_A, 32'd7); push("beq_exv", S_EXV_A, 1);
        tick();

        // BGEZ on a negative operand
        wb_write(5'd1, 32'h8000_0000);
        inst_in = i_type(OP_BGEZ, 5'd1, 5'd0, 16'h0010);
        push("bgez_neg", S_BR, 0);
        settle();
        tick();
        wb_we = 1'b0;

        // BGEZ on zero is taken
        inst_in = i_type(OP_BGEZ, 5'd4, 5'd0, 16'h0010); pc = 32'h200;
        push("bgez_zero", S_BR, 1); push("bgez_target", S_PCB, 32'h244);
        settle();
        tick();

        // Immediate extension
        inst_in = i_type(OP_ANDI, 5'd0, 5'd8, 16'h8001);
        push("andi_imm", S_IMM, 32'h0000_8001); push("andi_ex", S_EX, 32'b000111);
        tick();
        inst_in = i_type(OP_ADDI, 5'd0, 5'd8, 16'h8001);
        push("addi_imm", S_IMM, 32'hFFFF_8001);
        tick();

        // Unknown opcode
        inst_in = {6'b111111, 26'h0};
        push("bad_exc", S_EXC, 1);
        settle();
        push("bad_exv", S_EXV_A, 0); push("bad_ex", S_EX, 0);
        tick();

        // Register 0 ignores writes
        wb_write(5'd0, 32'hFFFF);
        inst_in = i_type(OP_ADDI, 5'd0, 5'd9, 16'h0003);
        push("zero_bypass", S_D1_A, 0);
        tick();
        wb_we = 1'b0;
        push("zero_read", S_D1_A, 0);
        tick();

        // Load to r0 never stalls
        inst_in = i_type(OP_LW, 5'd0, 5'd0, 16'h0000);
        push("lw_m", S_M, 32'b010); push("lw_wb", S_WB, 32'b11); push("lw_exv", S_EXV_A, 1);
        tick();
        inst_in = r_type(5'd0, 5'd0, 5'd10);
        push("r0_nohold_a", S_HOLD_A, 0); push("r0_nohold_b", S_HOLD_B, 0);
        settle();
        push("r0_issue_a", S_EXV_A, 1); push("r0_issue_b", S_EXV_B, 1);
        tick();

        // Load-use: 1 stall for instance a, 3 for instance b
        inst_in = i_type(OP_LW, 5'd0, 5'd3, 16'h0004);
        tick();
        inst_in = r_type(5'd3, 5'd4, 5'd7);
        push("lu_hold_a", S_HOLD_A, 1); push("lu_holdif_a", S_HOLDIF_A, 1);
        push("lu_hold_b", S_HOLD_B, 1); push("lu_holdif_b", S_HOLDIF_B, 1);
        settle();
        push("lu_bub_a", S_EXV_A, 0); push("lu_bub1_b", S_EXV_B, 0);
        tick();
        push("lu_rel_a", S_HOLD_A, 0); push("lu_hold2_b", S_HOLD_B, 1);
        settle();
        push("lu_issue_a", S_EXV_A, 1); push("lu_add_ex", S_EX, 32'b100100);
        push("lu_add_rd", S_RD_A, 32'd7); push("lu_bub2_b", S_EXV_B, 0);
        tick();
        wb_write(5'd3, 32'hABCD);
        push("lu_still_a", S_HOLD_A, 0); push("lu_hold3_b", S_HOLD_B, 1);
        settle();
        push("lu_bub3_b", S_EXV_B, 0); push("lu_wb_bypass_a", S_D1_A, 32'hABCD);
        tick();
        wb_we = 1'b0;
        push("lu_rel_b", S_HOLD_B, 0);
        settle();
        push("lu_issue_b", S_EXV_B, 1); push("lu_wb_pick_b", S_D1_B, 32'hABCD);
        tick();

        // Flush wins over a load-use hazard
        inst_in = i_type(OP_LW, 5'd0, 5'd3, 16'h0000);
        tick();
        inst_in = r_type(5'd3, 5'd4, 5'd7); flush_id = 1'b1;
        push("fl_hold_a", S_HOLD_A, 0); push("fl_hold_b", S_HOLD_B, 0);
        settle();
        push("fl_bub_a", S_EXV_A, 0); push("fl_bub_b", S_EXV_B, 0);
        tick();
        flush_id = 1'b0;
        push("fl_after_a", S_HOLD_A, 0); push("fl_after_b", S_HOLD_B, 0);
        settle();
        push("fl_issue_b", S_EXV_B, 1);
        tick();

        // Reset in the middle of a stall
        inst_in = i_type(OP_LW, 5'd0, 5'd3, 16'h0000);
        tick();
        inst_in = r_type(5'd3, 5'd4, 5'd7);
        push("mr_hold1_b", S_HOLD_B, 1);
        settle();
        tick();
        push("mr_hold2_b", S_HOLD_B, 1); push("mr_free_a", S_HOLD_A, 0);
        settle();
        push("mr_issue_a", S_EXV_A, 1);
        tick();
        push("mr_hold3_b", S_HOLD_B, 1);
        settle();
        #1 rst = 1'b1;
        push("mr_exv_a", S_EXV_A, 0); push("mr_ex", S_EX, 0); push("mr_wb", S_WB, 0);
        push("mr_rd", S_RD_A, 0); push("mr_d1_b", S_D1_B, 0); push("mr_hold_b", S_HOLD_B, 0);
        settle();
        @(posedge clk);
        #1 rst = 1'b0;
        push("mr_post_hold_b", S_HOLD_B, 0);
        settle();
        push("mr_post_d1_b", S_D1_B, 0); push("mr_post_exv_b", S_EXV_B, 1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_stage_param.md
Name: id_stage_param

Overview:
- Parametrised successor decode stage for the MIPS pipeline: register file, control decode, load-use hazard detection and the ID/EX pipeline register in one block.
- Adds over the previous generation:
  - clocked register-file writes with write-through bypass
  - sign/zero immediate extension chosen by opcode
  - signed branch compare
  - configurable multi-cycle load-use stall
  - explicit ex_valid on the ID/EX register
  - asynchronous reset
- Sits between the IF/ID register and EX.

Parameters:
- DATA_W, 32, datapath width; pc, register and immediate width.
- REG_DEPTH, 32, number of architectural registers; ADDR_W = $clog2(REG_DEPTH), must be ≤ 5.
- LOAD_LAT, 1, load-use stall cycles inserted per hazard; range 1..3.
- ZERO_REG, 1, when 1 register 0 reads 0, ignores writes and never raises a hazard.

Ports:
- clk, in, 1, clock; all state updates on its rising edge.
- rst, in, 1, asynchronous active-high reset.
- inst_in, in, 32, instruction from IF/ID.
- if_valid, in, 1, inst_in is a real instruction.
- pc, in, DATA_W, pc of inst_in.
- flush_id, in, 1, squash the instruction in ID.
- wb_we, in, 1, write-back enable.
- wb_addr, in, ADDR_W, write-back register.
- wb_data, in, DATA_W, write-back data.
- hold_pc, out, 1, freeze pc.
- hold_if, out, 1, freeze IF/ID.
- br, out, 1, branch taken (combinational).
- pc_branch, out, DATA_W, branch target (combinational).
- exception, out, 1, unknown opcode in ID (combinational).
- ex_valid, out, 1, ID/EX holds a real instruction.
- ex, out, 6, EX control.
- m, out, 3, MEM control; m[2] branch, m[1] mem read, m[0] mem write.
- wb, out, 2, WB control.
- rs, out, ADDR_W, registered source register.
- rt, out, ADDR_W, registered target register.
- rd, out, ADDR_W, registered destination register.
- imm, out, DATA_W, registered extended immediate.
- data_1, out, DATA_W, registered rs operand.
- data_2, out, DATA_W, registered rt operand.

Behaviour:
- Reset (async):
  - all registers cleared to 0; every registered output and the stall counter go to 0; ex_valid=0.
  - hold_pc=hold_if=0 while rst is high.
- Register file:
  - written at posedge when wb_we=1; writes to reg 0 are dropped when ZERO_REG=1.
  - reads are combinational on inst_in[25:21] and [20:16], truncated to ADDR_W.
  - bypass: if wb_we and wb_addr equals the read address (and it is not the suppressed reg 0), the read returns wb_data in the same cycle.
- Decode table (opcode → ex/m/wb/jump):
  - 000000 R: 100100 / 000 / 10 / 0
  - 001000 ADDI: 000001 / 000 / 10 / 0
  - 001001 ADDIU: same as ADDI
  - 001100 ANDI: 000111 / 000 / 10 / 0
  - 000100 BEQ: 000010 / 100 / 00 / 1
  - 000001 BGEZ: 000100 / 100 / 00 / 1
  - 100011 LW: 000001 / 010 / 11 / 0
  - 101011 SW: 000001 / 001 / 00 / 0
  - any other opcode: all fields 0; exception=1 when if_valid && !flush_id.
- Immediate: zero-extended for ANDI; sign-extended from bit 15 for all other opcodes.
- Branch:
  - pc_branch = pc + 4 + (imm << 2), modulo 2^DATA_W.
  - BEQ taken when op1 == op2; BGEZ taken when signed op1 ≥ 0. op1/op2 are the bypassed read data.
  - br = taken & jump & if_valid & !flush_id & !stall.
- Hazard detection:
  - hz = ex_valid & m[1] & (rt == rs_id || rt == rt_id), excluding index 0 when ZERO_REG=1; rs_id/rt_id are the current instruction fields.
  - stall = (hz || stall_cnt != 0) && !flush_id && if_valid.
  - hold_pc = hold_if = stall.
  - When hz starts a stall, stall_cnt loads LOAD_LAT-1; it decrements each stalled cycle down to 0.
  - Total stall length is exactly LOAD_LAT cycles.
- ID/EX register, updated every posedge:
  - if stall, flush_id, !if_valid or exception: insert a bubble, i.e. ex/m/wb=0 and ex_valid=0. rs, rt, rd, imm, data_1, data_2 are still captured.
  - otherwise capture the decoded values and set ex_valid=1.
- Simultaneous events:
  - flush_id beats hazard: bubble, hold deasserted, stall_cnt cleared.
  - A write-back to the register under stall is picked up by the bypass at release.
  - rst mid-stall aborts the stall immediately.

Decomposition:
- Package id_pkg:
  - opcode localparams.
  - ctrl_t struct {ex[5:0], m[2:0], wb[1:0], jump}.
  - ID_CTRL_BUBBLE constant.
  - function decode_ctrl(opcode) returning ctrl_t.
- Sub-module id_regfile, parametrised by DATA_W, REG_DEPTH and ZERO_REG, containing the async reset, write port and bypassed read ports.

Test Plan:
- Reset, then write reg5=0x1234 and issue ADDI rs=5 in the same cycle as the write → next cycle data_1=0x1234 (bypass), ex=000001, wb=10, ex_valid=1.
- LW rt=3, then ADD rs=3 with LOAD_LAT=1 → hold_pc=hold_if=1 for one cycle, then ADD issues with ex_valid=1.
  - With LOAD_LAT=3 → hold for 3 cycles and three bubbles (ex_valid=0).
- ZERO_REG=1: write 0xFFFF to reg0 → reads return 0; LW rt=0 followed by use of reg0 → no stall.
- BEQ with r1=r2=7, pc=0x100, imm=0xFFFE → br=1, pc_branch=0x0FC.
  - BGEZ with r1=0x80000000 → br=0.
- ANDI imm=0x8001 → imm=0x00008001; ADDI imm=0x8001 → imm=0xFFFF8001.
- Opcode 111111 → exception=1 and a bubble.
  - flush_id asserted during a load-use hazard → hold=0, bubble, and no stall on the next cycle.
  - rst asserted mid-stall → all outputs 0 asynchronously.
